// File: rtl/i2c_pkg.sv
// Shared constants for the byte-level I2C master: command codes, FSM encoding
// and default timing.
package i2c_pkg;

   localparam int QTR_DIV_DFLT = 15;

   // Cycles a released SCL needs to reach the synchronizer output.
   localparam int SYNC_LAT = 2;

   localparam logic [1:0] CMD_START = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_STOP  = 2'd3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_BIT   = 3'd2;
   localparam logic [2:0] ST_ACK   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period counter: counts QTR_DIV cycles while running, holds on stall,
// and strobes qtr_done on the last cycle of each quarter.
module i2c_tick_gen #(
   parameter int QTR_DIV = 15,
   parameter int CNT_W   = 8
) (
   input  logic             sys_clk,
   input  logic             resetn,
   input  logic             run,
   input  logic             stall,
   output logic [CNT_W-1:0] cnt,
   output logic             qtr_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(QTR_DIV - 1);

   assign qtr_done = run && !stall && (cnt == LAST);

   always_ff @(posedge sys_clk) begin
      if (!resetn || !run) begin
         cnt <= '0;
      end else if (!stall) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START / WRITE / READ / STOP commands become
// open-drain SCL/SDA activity, one bit slot = four quarters.
module i2c_byte_master
   import i2c_pkg::*;
#(
   parameter int QTR_DIV = QTR_DIV_DFLT,
   parameter int CNT_W   = 8
) (
   input  logic       sys_clk,
   input  logic       resetn,
   // cmd_valid/cmd_ready: a command transfers on a cycle where both are high;
   // cmd/wr_data/rd_nack are sampled on that edge only.
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wr_data,
   input  logic       rd_nack,
   output logic       rsp_valid,
   output logic [7:0] rd_data,
   output logic       ack_n,
   output logic       err,
   output logic       busy_bus,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic [2:0] dbg_state
);

   logic [2:0]       state;
   logic [1:0]       qtr;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             is_read;
   logic             nack;
   logic             ack_smp;
   logic             fin;
   logic             err_p1;
   logic             err_p2;
   logic             scl_m, scl_s;
   logic             sda_m, sda_s;
   logic [CNT_W-1:0] cnt;
   logic             qtr_done;
   logic             run;
   logic             stall;
   logic             accept;
   logic             legal;

   assign cmd_ready = (state == ST_IDLE) && !err_p1 && !err_p2;
   assign accept    = cmd_valid && cmd_ready;
   assign legal     = (cmd == CMD_START) || busy_bus;
   assign run       = (state != ST_IDLE) && !fin;
   assign dbg_state = state;

   // The quarter freezes just past the synchronizer latency while released
   // SCL still reads low, so stretching adds exactly the time SCL is held.
   assign stall = !scl_oe && !scl_s && (cnt == CNT_W'(SYNC_LAT));

   i2c_tick_gen #(
      .QTR_DIV (QTR_DIV),
      .CNT_W   (CNT_W)
   ) u_tick (
      .sys_clk  (sys_clk),
      .resetn   (resetn),
      .run      (run),
      .stall    (stall),
      .cnt      (cnt),
      .qtr_done (qtr_done)
   );

   always_ff @(posedge sys_clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         qtr       <= 2'd0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         is_read   <= 1'b0;
         nack      <= 1'b0;
         ack_smp   <= 1'b1;
         fin       <= 1'b0;
         err_p1    <= 1'b0;
         err_p2    <= 1'b0;
         scl_m     <= 1'b1;
         scl_s     <= 1'b1;
         sda_m     <= 1'b1;
         sda_s     <= 1'b1;
         rsp_valid <= 1'b0;
         rd_data   <= 8'h00;
         ack_n     <= 1'b1;
         err       <= 1'b0;
         busy_bus  <= 1'b0;
         scl_oe    <= 1'b0;
         sda_oe    <= 1'b0;
      end else begin
         scl_m     <= scl_in;
         scl_s     <= scl_m;
         sda_m     <= sda_in;
         sda_s     <= sda_m;
         rsp_valid <= err_p2;
         err       <= err_p2;
         err_p2    <= err_p1;
         err_p1    <= 1'b0;

         if (accept) begin
            if (!legal) begin
               err_p1 <= 1'b1;
            end else begin
               qtr     <= 2'd0;
               bit_cnt <= 3'd0;
               case (cmd)
                  CMD_START: begin
                     state  <= ST_START;
                     scl_oe <= 1'b0;
                     sda_oe <= 1'b0;
                  end
                  CMD_WRITE: begin
                     state   <= ST_BIT;
                     is_read <= 1'b0;
                     shreg   <= wr_data;
                     sda_oe  <= !wr_data[7];
                  end
                  CMD_READ: begin
                     state   <= ST_BIT;
                     is_read <= 1'b1;
                     nack    <= rd_nack;
                     sda_oe  <= 1'b0;
                  end
                  default: begin
                     state  <= ST_STOP;
                     sda_oe <= 1'b1;
                  end
               endcase
            end
         end else if (fin) begin
            fin       <= 1'b0;
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            case (state)
               ST_START: busy_bus <= 1'b1;
               ST_STOP:  busy_bus <= 1'b0;
               ST_ACK: begin
                  if (is_read) rd_data <= shreg;
                  else         ack_n   <= ack_smp;
               end
               default: ;
            endcase
         end else if (qtr_done) begin
            qtr <= qtr + 2'd1;
            case (qtr)
               2'd0: scl_oe <= 1'b0;
               2'd1: if (state == ST_START) sda_oe <= 1'b1;
               2'd2: begin
                  if (state == ST_STOP) sda_oe <= 1'b0;
                  else                  scl_oe <= 1'b1;
                  if (state == ST_BIT) shreg   <= {shreg[6:0], sda_s};
                  if (state == ST_ACK) ack_smp <= sda_s;
               end
               default: begin
                  // End of slot: shreg[7] already holds the next bit to send.
                  if (state == ST_BIT) begin
                     if (bit_cnt == 3'd7) begin
                        state  <= ST_ACK;
                        sda_oe <= is_read ? !nack : 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sda_oe  <= is_read ? 1'b0 : !shreg[7];
                     end
                  end else begin
                     fin <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule
